scale_pipeline: RTL

SCALE_PIPELINE -- requirements
Module: scale_pipeline

---
 rtl/scale_pipeline.sv | 84 ++++++++
 1 files changed

// File: rtl/scale_pipeline.sv
// Elastic multiply pipeline: stage i scales the upstream word by (FACTOR_BASE+i),
// with per-stage valid/ready back-pressure, synchronous flush and a registered occupancy count.
module scale_pipeline #(
    parameter int WIDTH       = 32,
    parameter int STAGES      = 2,
    parameter int FACTOR_BASE = 2
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           io_in_valid,
    output logic                           io_in_ready,
    input  logic [WIDTH-1:0]               io_in_data,
    output logic                           io_out_valid,
    input  logic                           io_out_ready,
    output logic [WIDTH-1:0]               io_out_data,
    input  logic                           io_flush,
    output logic [$clog2(STAGES+1)-1:0]    io_occupancy
);

    localparam int OCC_W = $clog2(STAGES + 1);

    logic [STAGES-1:0] r_valid;
    logic [WIDTH-1:0]  r_data [STAGES];
    logic [OCC_W-1:0]  r_occupancy;

    logic [STAGES:0]   w_ready;
    logic [STAGES-1:0] w_upValid;
    logic [WIDTH-1:0]  w_upData [STAGES];
    logic [WIDTH-1:0]  w_product [STAGES];
    logic [STAGES-1:0] w_load;
    logic [STAGES-1:0] w_validNext;
    logic [OCC_W-1:0]  w_occNext;

    // Ready ripples back from the consumer; a stage can take a word if it is empty
    // or its own word is leaving this cycle. Flush overrides every transfer.
    always_comb begin
        w_ready              = '0;
        w_upValid            = '0;
        w_load               = '0;
        w_validNext          = '0;
        w_occNext            = '0;
        w_ready[STAGES]      = io_out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            w_ready[i] = !r_valid[i] || w_ready[i+1];
        end
        w_upValid[0] = io_in_valid;
        w_upData[0]  = io_in_data;
        for (int i = 1; i < STAGES; i++) begin
            w_upValid[i] = r_valid[i-1];
            w_upData[i]  = r_data[i-1];
        end
        for (int i = 0; i < STAGES; i++) begin
            w_product[i]   = w_upData[i] * WIDTH'(FACTOR_BASE + i);
            w_load[i]      = w_upValid[i] && w_ready[i] && !io_flush;
            w_validNext[i] = io_flush ? 1'b0 : (w_ready[i] ? w_upValid[i] : r_valid[i]);
            w_occNext      = w_occNext + OCC_W'(w_validNext[i]);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_valid     <= '0;
            r_occupancy <= '0;
        end else begin
            r_valid     <= w_validNext;
            r_occupancy <= w_occNext;
        end
    end

    // Data is only meaningful under its valid bit, so it carries no reset.
    always_ff @(posedge clock) begin
        for (int i = 0; i < STAGES; i++) begin
            if (w_load[i]) begin
                r_data[i] <= w_product[i];
            end
        end
    end

    assign io_in_ready  = w_ready[0] && !io_flush;
    assign io_out_valid = r_valid[STAGES-1];
    assign io_out_data  = r_data[STAGES-1];
    assign io_occupancy = r_occupancy;

endmodule
